// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a 2**DEPTH character FIFO and free-running baud divider.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_in,
  input  logic              fifo_write,
  output logic [DEPTH:0]    fifo_space,
  output logic              fifo_full,
  output logic              fifo_empty,
  input  logic [15:0]       clkdiv,
  input  logic [3:0]        nbits,
  input  logic [1:0]        parity,
  input  logic              stop2,
  output logic              busy,
  output logic              tx_done,
  output logic              baudclk,
  output logic              tx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [DEPTH:0] FIFO_ENTRIES = {1'b1, {DEPTH{1'b0}}};
  localparam logic [3:0]     NB_MIN       = 4'd5;
  localparam logic [3:0]     NB_MAX       = 4'(DWIDTH);

  // ---------------- baud divider ----------------
  logic [15:0] baud_ctr_q, baud_ctr_d;
  logic        baud_tick;

  always_comb begin
    baud_tick  = (baud_ctr_q == clkdiv);
    // >= also recovers when clkdiv is lowered below the current count
    baud_ctr_d = (baud_ctr_q >= clkdiv) ? 16'd0 : baud_ctr_q + 16'd1;
  end

  assign baudclk = (baud_ctr_q == 16'd1);

  // ---------------- character FIFO ----------------
  logic [DWIDTH-1:0] fifo_mem [0:(1<<DEPTH)-1];
  logic [DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]    count_q, count_d;
  logic [DWIDTH-1:0] head_q;
  logic              wr_en;
  logic              pop;

  assign fifo_full  = (count_q == FIFO_ENTRIES);
  assign fifo_empty = (count_q == '0);
  assign fifo_space = FIFO_ENTRIES - count_q;

  always_comb begin
    wr_en    = fifo_write & ~fifo_full;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= fifo_in;
    end
  end

  // Registered head read; a write landing on the next head slot is forwarded.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_q <= fifo_in;
    end else begin
      head_q <= fifo_mem[rd_ptr_d];
    end
  end

  // ---------------- transmit FSM ----------------
  logic [2:0]        state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [3:0]        nbits_q, nbits_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              tx_done_q, tx_done_d;
  logic [3:0]        nb_clamped;
  logic              load;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
  logic par_acc_q, par_acc_d;
`else
  logic unused_parity;
  assign unused_parity = ^parity;
`endif

  always_comb begin
    if (nbits < NB_MIN) begin
      nb_clamped = NB_MIN;
    end else if (nbits > NB_MAX) begin
      nb_clamped = NB_MAX;
    end else begin
      nb_clamped = nbits;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    stop2_d   = stop2_q;
    tx_done_d = 1'b0;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_acc_d = par_acc_q;
`endif

    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          load = ~fifo_empty;
        end
        S_START: begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end
        S_DATA: begin
          data_d = data_q >> 1;
`ifdef UART_TX_PARITY_EN
          par_acc_d = par_acc_q ^ data_q[0];
`endif
          if (bit_cnt_q == nbits_q - 4'd1) begin
            bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_d   = S_STOP;
          bit_cnt_d = 4'd0;
        end
`endif
        S_STOP: begin
          if (stop2_q && (bit_cnt_q == 4'd0)) begin
            bit_cnt_d = 4'd1;
          end else begin
            tx_done_d = 1'b1;
            if (fifo_empty) begin
              state_d = S_IDLE;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Shadow the frame format so mid-frame input changes only affect the next character
    if (load) begin
      state_d   = S_START;
      data_d    = head_q;
      nbits_d   = nb_clamped;
      stop2_d   = stop2;
      bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (parity == 2'd1) || (parity == 2'd2);
      par_odd_d = (parity == 2'd2);
      par_acc_d = 1'b0;
`endif
    end
  end

  assign pop = load;

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_acc_q ^ par_odd_q;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_ctr_q <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      data_q     <= '0;
      nbits_q    <= NB_MIN;
      bit_cnt_q  <= 4'd0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_acc_q  <= 1'b0;
`endif
    end else begin
      baud_ctr_q <= baud_ctr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      data_q     <= data_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_acc_q  <= par_acc_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign tx_done = tx_done_q;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a mid-bit sampling receiver checks frames, monitors time frame edges.
// Expectations adapt to whether UART_TX_PARITY_EN is defined.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  fifo_in;
  logic        fifo_write;
  logic [4:0]  fifo_space;
  logic        fifo_full, fifo_empty;
  logic [15:0] clkdiv;
  logic [3:0]  nbits;
  logic [1:0]  parity;
  logic        stop2;
  logic        busy, tx_done, baudclk, tx;

  logic [7:0]  s_fifo_in;
  logic        s_fifo_write;
  logic [2:0]  s_fifo_space;
  logic        s_fifo_full, s_fifo_empty;
  logic [15:0] s_clkdiv;
  logic        s_busy, s_tx_done, s_baudclk, s_tx;

  uart_tx_cfg #(.DEPTH(4), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .fifo_in(fifo_in), .fifo_write(fifo_write),
    .fifo_space(fifo_space), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .clkdiv(clkdiv), .nbits(nbits), .parity(parity), .stop2(stop2),
    .busy(busy), .tx_done(tx_done), .baudclk(baudclk), .tx(tx)
  );

  uart_tx_cfg #(.DEPTH(2), .DWIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .fifo_in(s_fifo_in), .fifo_write(s_fifo_write),
    .fifo_space(s_fifo_space), .fifo_full(s_fifo_full), .fifo_empty(s_fifo_empty),
    .clkdiv(s_clkdiv), .nbits(nbits), .parity(parity), .stop2(stop2),
    .busy(s_busy), .tx_done(s_tx_done), .baudclk(s_baudclk), .tx(s_tx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic prev_busy = 1'b0;
  int busy_rise_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int fall_cnt = 0;
  int tx_low_cnt = 0;
  int s_done_cnt = 0;
  always @(negedge clk) begin
    prev_busy <= busy;
    if (busy && !prev_busy) busy_rise_cyc <= cyc;
    if (!busy && prev_busy) fall_cnt <= fall_cnt + 1;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (!tx) tx_low_cnt <= tx_low_cnt + 1;
    if (s_tx_done) s_done_cnt <= s_done_cnt + 1;
  end

  int total = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] c);
    fifo_in    = c;
    fifo_write = 1'b1;
    @(negedge clk);
    fifo_write = 1'b0;
  endtask

  task automatic push_s(input logic [7:0] c);
    s_fifo_in    = c;
    s_fifo_write = 1'b1;
    @(negedge clk);
    s_fifo_write = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (busy !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    check(tag, 32'(t < 1000), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    check(tag, 32'(t < 3000), 32'd1);
    @(negedge clk);
  endtask

  // Receiver: find the start edge, then sample each bit in its middle.
  task automatic rx_frame(input int p, input int nb, input int np, input int ns,
                          output logic [7:0] d, output logic pb, output int sc);
    int t = 0;
    d  = 8'h00;
    pb = 1'b0;
    while (tx !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    check("rx_start_found", 32'(t < 3000), 32'd1);
    sc = cyc;
    repeat (p / 2) @(negedge clk);
    check("rx_start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < nb; i++) begin
      repeat (p) @(negedge clk);
      d[i] = tx;
    end
    for (int i = 0; i < np; i++) begin
      repeat (p) @(negedge clk);
      pb = tx;
    end
    for (int i = 0; i < ns; i++) begin
      repeat (p) @(negedge clk);
      check("rx_stop_bit", 32'(tx), 32'd1);
    end
  endtask

  logic [7:0] d0, d1, d2;
  logic       pb;
  int sc0, sc1, sc2, base, base2, t;

  initial begin
    rst = 1'b1; fifo_in = 8'h00; fifo_write = 1'b0; clkdiv = 16'd3;
    nbits = 4'd8; parity = 2'd0; stop2 = 1'b0;
    s_fifo_in = 8'h00; s_fifo_write = 1'b0; s_clkdiv = 16'd100;
    repeat (3) @(negedge clk);

    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_baudclk", 32'(baudclk), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_space", 32'(fifo_space), 32'd16);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 frame of 0xA5
    base = done_cnt;
    push(8'hA5);
    check("8n1_space_after_write", 32'(fifo_space), 32'd15);
    check("8n1_empty_after_write", 32'(fifo_empty), 32'd0);
    rx_frame(4, 8, 0, 1, d0, pb, sc0);
    check("8n1_data", 32'(d0), 32'hA5);
    wait_idle("8n1_idle");
    check("8n1_len", 32'(done_cyc - busy_rise_cyc), 32'd40);
    check("8n1_done_pulses", 32'(done_cnt - base), 32'd1);
    check("8n1_busy_low", 32'(busy), 32'd0);
    check("8n1_space_back", 32'(fifo_space), 32'd16);

    // 7-bit 0x55, even then odd parity
    nbits = 4'd7;
    parity = 2'd1;
    push(8'h55);
`ifdef UART_TX_PARITY_EN
    rx_frame(4, 7, 1, 1, d0, pb, sc0);
    check("even_parity_bit", 32'(pb), 32'd0);
`else
    rx_frame(4, 7, 0, 1, d0, pb, sc0);
`endif
    check("even_data", 32'(d0), 32'h55);
    wait_idle("even_idle");
`ifdef UART_TX_PARITY_EN
    check("even_len", 32'(done_cyc - busy_rise_cyc), 32'd40);
`else
    check("noparity_len", 32'(done_cyc - busy_rise_cyc), 32'd36);
`endif
    parity = 2'd2;
    push(8'h55);
`ifdef UART_TX_PARITY_EN
    rx_frame(4, 7, 1, 1, d0, pb, sc0);
    check("odd_parity_bit", 32'(pb), 32'd1);
`else
    rx_frame(4, 7, 0, 1, d0, pb, sc0);
`endif
    check("odd_data", 32'(d0), 32'h55);
    wait_idle("odd_idle");

    // Back-to-back with two stop bits
    nbits = 4'd8; parity = 2'd0; stop2 = 1'b1;
    base = done_cnt;
    base2 = fall_cnt;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    rx_frame(4, 8, 0, 2, d0, pb, sc0);
    rx_frame(4, 8, 0, 2, d1, pb, sc1);
    rx_frame(4, 8, 0, 2, d2, pb, sc2);
    check("b2b_data0", 32'(d0), 32'h01);
    check("b2b_data1", 32'(d1), 32'h02);
    check("b2b_data2", 32'(d2), 32'h03);
    check("b2b_gap01", 32'(sc1 - sc0), 32'd44);
    check("b2b_gap12", 32'(sc2 - sc1), 32'd44);
    check("b2b_busy_held", 32'(fall_cnt - base2), 32'd0);
    wait_idle("b2b_idle");
    check("b2b_done_pulses", 32'(done_cnt - base), 32'd3);

    // nbits clamp and shadow latch
    stop2 = 1'b0; nbits = 4'd3;
    push(8'hFF);
    wait_busy("clamp_busy");
    nbits = 4'd8;
    rx_frame(4, 5, 0, 1, d0, pb, sc0);
    check("clamp_data", 32'(d0), 32'h1F);
    wait_idle("clamp_idle");
    check("clamp_len", 32'(done_cyc - busy_rise_cyc), 32'd28);

    // Reset during DATA with two characters queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_busy("rst_mid_busy");
    repeat (8) @(negedge clk);
    check("rst_mid_pre_busy", 32'(busy), 32'd1);
    check("rst_mid_pre_space", 32'(fifo_space), 32'd14);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_empty", 32'(fifo_empty), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_space", 32'(fifo_space), 32'd16);
    rst = 1'b0;
    @(negedge clk);
    base = done_cnt;
    base2 = tx_low_cnt;
    repeat (200) @(negedge clk);
    check("rst_mid_no_frames", 32'(tx_low_cnt - base2), 32'd0);
    check("rst_mid_no_done", 32'(done_cnt - base), 32'd0);

    // FIFO overflow on the 4-entry instance: align so the first pop lands right after write 1
    t = 0;
    while (s_baudclk !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check("ovf_baudclk_found", 32'(t < 300), 32'd1);
    repeat (98) @(negedge clk);
    push_s(8'h41);
    push_s(8'h42);
    push_s(8'h43);
    push_s(8'h44);
    push_s(8'h45);
    push_s(8'h46);
    check("ovf_full", 32'(s_fifo_full), 32'd1);
    check("ovf_space", 32'(s_fifo_space), 32'd0);
    t = 0;
    while (s_done_cnt < 5 && t < 6000) begin @(negedge clk); t++; end
    check("ovf_frames_timeout", 32'(t < 6000), 32'd1);
    repeat (1500) @(negedge clk);
    check("ovf_frame_count", 32'(s_done_cnt), 32'd5);
    check("ovf_empty_after", 32'(s_fifo_empty), 32'd1);
    check("ovf_busy_after", 32'(s_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter for the common peripheral set. It has an internal character FIFO of 2**DEPTH entries and a free-running baud divider. Frame format (5..DWIDTH data bits, optional parity, 1 or 2 stop bits) is selectable per character. Frames are sent back-to-back, with no idle bit between them. It sits behind the CPU/wishbone UART register block and drives the pad-level tx line.

## Interface
- DEPTH, 4, log2 of FIFO entries (FIFO holds 2**DEPTH characters)
- DWIDTH, 8, maximum data bits per character (5..8)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- fifo_in  in  DWIDTH  character to enqueue
- fifo_write  in  1  enqueue strobe, one character per cycle
- fifo_space  out  DEPTH+1  free FIFO entries
- fifo_full  out  1  FIFO full; writes are dropped while high
- fifo_empty  out  1  FIFO holds no characters
- clkdiv  in  16  baud period minus one, in clk cycles
- nbits  in  4  data bits per character; clamped to 5..DWIDTH
- parity  in  2  0 = none, 1 = even, 2 = odd, 3 = none
- stop2  in  1  1 = two stop bits
- busy  out  1  a frame is in progress
- tx_done  out  1  one-cycle pulse at the end of each frame
- baudclk  out  1  debug: high for one cycle when baud_ctr == 1
- tx  out  1  serial output, idle high

## Operation
- **Baud counter:** counts 0..clkdiv, then wraps to 0. If baud_ctr > clkdiv (clkdiv lowered at runtime), it goes to 0 on the next cycle. A tick is the cycle where baud_ctr == clkdiv, so one bit lasts clkdiv+1 cycles.
- **FIFO:** circular buffer. A write while full is dropped, even if a pop happens in the same cycle.
- **States:** IDLE, START, DATA, PARITY, STOP. All transitions happen only on a tick.
- **IDLE → START:** on a tick with ~fifo_empty. That cycle pops the head character and latches char, clamped nbits, parity and stop2 into shadow registers. Input changes mid-frame do not affect the current frame.
- **START → DATA:** after one bit time.
- **DATA:** sends shadow data LSB first, nbits bit times. Character bits at and above nbits are ignored.
- **DATA → PARITY or STOP:** goes to PARITY if parity is 1 or 2, otherwise to STOP. PARITY lasts one bit time.
- **Parity bit:** even = XOR of the transmitted data bits; odd = its inverse.
- **STOP:** lasts 1 bit time, or 2 if stop2 was latched.
- **End of the final stop tick:**
  - tx_done pulses.
  - If the FIFO is non-empty, pop and go straight to START, so no idle gap.
  - Otherwise go to IDLE.
- **tx value per state:** IDLE 1, START 0, DATA data bit, PARITY parity bit, STOP 1.
- **busy:** high in every state except IDLE.

## Timing
- **Reset values:** tx = 1, busy = 0, tx_done = 0, baudclk = 0, fifo_empty = 1, fifo_full = 0, fifo_space = 2**DEPTH, baud_ctr = 0, state IDLE. The FIFO is cleared.
- **Reset mid-frame:** the frame is aborted, tx is 1 on the cycle after rst is sampled, and queued characters are discarded.
- **tx is registered:** it changes one clk after the state register changes, which is two clks after the tick edge.
- **Start latency:** a write is visible to the FSM on the next cycle. If a tick coincides with the write cycle, the start waits for the following tick.
- **Frame length:** (1 + n + p + s) × (clkdiv + 1) cycles, where n = clamped nbits, p = 1 if parity is enabled (else 0), s = 1 or 2.
- **Flag timing:** fifo_space, fifo_full and fifo_empty update the cycle after a write or pop. A simultaneous accepted write and pop leaves fifo_space unchanged.
- **tx_done timing:** asserted in the cycle after the final stop tick.
- **clkdiv = 0:** every cycle is a tick, giving one bit per clk.

## Configuration
- **UART_TX_PARITY_EN defined:** parity is supported as described above.
- **UART_TX_PARITY_EN undefined:** the parity input is ignored, PARITY is never entered, and the frame length uses p = 0. The parity logic is not synthesised.

## Test plan
- **8N1 frame:** clkdiv = 3, nbits = 8, parity = 0, stop2 = 0; write 0xA5.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - tx_done pulses once, 40 cycles after start.
  - busy falls afterwards, and fifo_space returns to 16.
- **Parity:** nbits = 7, write 0x55 (four 1s).
  - With parity = 1 (even): parity bit = 0.
  - With parity = 2 (odd): parity bit = 1.
  - Without UART_TX_PARITY_EN: no parity bit, and the frame is 9 bits long.
- **Back-to-back with 2 stop bits:** stop2 = 1; write 0x01, 0x02, 0x03 on consecutive cycles.
  - Three 11-bit frames with a start bit immediately after each second stop bit.
  - Three tx_done pulses; busy stays high throughout.
- **FIFO overflow:** DEPTH = 2, clkdiv = 100; write 6 characters on consecutive cycles.
  - The first character is popped at the first tick; the next 4 fill the FIFO and the 6th is dropped.
  - fifo_full = 1 and fifo_space = 0 after the overflow.
  - Exactly 5 frames are transmitted.
- **Clamping and shadow latch:** set nbits = 3 and write 0xFF.
  - The frame carries 5 data bits.
  - Changing nbits to 8 mid-frame does not alter the current frame.
- **Reset mid-frame:** assert rst during DATA with 2 characters queued.
  - tx = 1 on the next cycle; fifo_empty = 1, busy = 0.
  - No further frames after rst is released.
